// File: rtl/mult_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and the state-to-opcode map
// for the shift-and-add multiply sequencer.
package mult_sequencer_pkg;

  localparam int DW_DEF  = 16;
  localparam int OPW_DEF = 12;
  localparam int HOLD_W  = 8;
  localparam int ITER_W  = 8;

  localparam logic [11:0] OP_IDLE     = 12'b000000001001;
  localparam logic [11:0] OP_LOAD_X   = 12'b000000001011;
  localparam logic [11:0] OP_LOAD_Y   = 12'b000000001100;
  localparam logic [11:0] OP_INIT_AND = 12'b001000000101;
  localparam logic [11:0] OP_SHL_B    = 12'b001000010011;
  localparam logic [11:0] OP_SHR_C    = 12'b000000101010;
  localparam logic [11:0] OP_FIX_BO   = 12'b100001001011;
  localparam logic [11:0] OP_FIX_NEG  = 12'b001000011000;
  localparam logic [11:0] OP_AO_A     = 12'b100000001001;
  localparam logic [11:0] OP_BO_B     = 12'b100001001011;
  localparam logic [11:0] OP_AND_CO   = 12'b001110000101;
  localparam logic [11:0] OP_AO_C     = 12'b010000101100;
  localparam logic [11:0] OP_ADD      = 12'b000000000000;
  localparam logic [11:0] OP_CO_C     = 12'b010010001100;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD_X   = 4'd1,
    ST_LOAD_Y   = 4'd2,
    ST_INIT_AND = 4'd3,
    ST_SHL_B    = 4'd4,
    ST_SHR_C    = 4'd5,
    ST_FIX_BO   = 4'd6,
    ST_FIX_NEG  = 4'd7,
    ST_AO_A     = 4'd8,
    ST_BO_B     = 4'd9,
    ST_AND_CO   = 4'd10,
    ST_AO_C     = 4'd11,
    ST_ADD      = 4'd12,
    ST_CO_C     = 4'd13,
    ST_DONE     = 4'd14
  } state_t;

  function automatic logic [11:0] state_opcode(input state_t s);
    case (s)
      ST_LOAD_X:   state_opcode = OP_LOAD_X;
      ST_LOAD_Y:   state_opcode = OP_LOAD_Y;
      ST_INIT_AND: state_opcode = OP_INIT_AND;
      ST_SHL_B:    state_opcode = OP_SHL_B;
      ST_SHR_C:    state_opcode = OP_SHR_C;
      ST_FIX_BO:   state_opcode = OP_FIX_BO;
      ST_FIX_NEG:  state_opcode = OP_FIX_NEG;
      ST_AO_A:     state_opcode = OP_AO_A;
      ST_BO_B:     state_opcode = OP_BO_B;
      ST_AND_CO:   state_opcode = OP_AND_CO;
      ST_AO_C:     state_opcode = OP_AO_C;
      ST_ADD:      state_opcode = OP_ADD;
      ST_CO_C:     state_opcode = OP_CO_C;
      default:     state_opcode = OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mult_sequencer_step_timer.sv
// Loadable hold counter: counts 0..hold_len-1, pulses expire on the last
// count and wraps to zero; clr forces the count back to zero.
module step_timer #(
  parameter int HW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [HW-1:0] hold_len,
  output logic          expire
);

  logic [HW-1:0] cnt_q;
  logic [HW-1:0] cnt_d;

  assign expire = (cnt_q == (hold_len - {{(HW-1){1'b0}}, 1'b1}));

  // next count: wrap on expiry or clear, otherwise increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = {HW{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(HW-1){1'b0}}, 1'b1};
    end
  end

  // count register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {HW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Opcode sequencer for an N_BITS shift-and-add multiply on the control/ALU
// datapath, with an optional two's-complement fixup in the last iteration.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int OPW         = OPW_DEF,
  parameter int N_BITS      = 5,
  parameter int STEP_CYCLES = 35,
  parameter int LONG_CYCLES = 100
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [DW-1:0]  op_x,
  input  logic [DW-1:0]  op_y,
  input  logic           c_sign,
  output logic [OPW-1:0] opcode,
  output logic [DW-1:0]  mem_dat_x,
  output logic [DW-1:0]  mem_dat_y,
  output logic           busy,
  output logic           done
);

  state_t              state_q, state_d, step_next;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [OPW-1:0]      opcode_q, opcode_d;
  logic [DW-1:0]       mem_dat_x_q, mem_dat_x_d;
  logic [DW-1:0]       mem_dat_y_q, mem_dat_y_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timer_clr;
  logic                expire;
  logic [HOLD_W-1:0]   hold_len;
  logic                last_iter;

  assign last_iter = (iter_q == ITER_W'(N_BITS - 1));
  assign hold_len  = (state_q == ST_AO_C) ? HOLD_W'(LONG_CYCLES) : HOLD_W'(STEP_CYCLES);

  step_timer #(.HW(HOLD_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .hold_len (hold_len),
    .expire   (expire)
  );

  // successor of each step; c_sign is only looked at in the last SHR_C
  always_comb begin
    step_next = ST_IDLE;
    case (state_q)
      ST_LOAD_X:   step_next = ST_LOAD_Y;
      ST_LOAD_Y:   step_next = ST_INIT_AND;
      ST_INIT_AND: step_next = ST_SHL_B;
      ST_SHL_B:    step_next = ST_SHR_C;
      ST_SHR_C:    step_next = (last_iter && c_sign) ? ST_FIX_BO : ST_AO_A;
      ST_FIX_BO:   step_next = ST_FIX_NEG;
      ST_FIX_NEG:  step_next = ST_AO_A;
      ST_AO_A:     step_next = ST_BO_B;
      ST_BO_B:     step_next = ST_AND_CO;
      ST_AND_CO:   step_next = ST_AO_C;
      ST_AO_C:     step_next = ST_ADD;
      ST_ADD:      step_next = ST_CO_C;
      ST_CO_C:     step_next = last_iter ? ST_DONE : ST_SHL_B;
      default:     step_next = ST_IDLE;
    endcase
  end

  // FSM control: accept, step advance on timer expiry, iteration counting
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    mem_dat_x_d = mem_dat_x_q;
    mem_dat_y_d = mem_dat_y_q;
    timer_clr   = 1'b0;
    if (state_q == ST_IDLE) begin
      timer_clr = 1'b1;
      if (start) begin
        state_d     = ST_LOAD_X;
        iter_d      = {ITER_W{1'b0}};
        mem_dat_x_d = op_x;
        mem_dat_y_d = op_y;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_DONE) begin
      timer_clr = 1'b1;
      state_d   = ST_IDLE;
      iter_d    = {ITER_W{1'b0}};
    end else if (expire) begin
      state_d = step_next;
      if (state_q == ST_CO_C) begin
        iter_d = last_iter ? {ITER_W{1'b0}} : (iter_q + {{(ITER_W-1){1'b0}}, 1'b1});
      end else begin
        iter_d = iter_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // outputs follow the next state so they change on the same edge
  always_comb begin
    opcode_d = OPW'(state_opcode(state_d));
    busy_d   = 1'b1;
    done_d   = 1'b0;
    if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      busy_d = 1'b0;
    end else begin
      busy_d = 1'b1;
    end
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      iter_q      <= {ITER_W{1'b0}};
      opcode_q    <= OPW'(OP_IDLE);
      mem_dat_x_q <= {DW{1'b0}};
      mem_dat_y_q <= {DW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      opcode_q    <= opcode_d;
      mem_dat_x_q <= mem_dat_x_d;
      mem_dat_y_q <= mem_dat_y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign opcode    = opcode_q;
  assign mem_dat_x = mem_dat_x_q;
  assign mem_dat_y = mem_dat_y_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
